// File: rtl/hilo_mult_unit_pkg.sv
// hilo_mult_unit_pkg
//   Shared definitions for the execute-stage HI/LO multiply unit and the
//   R-type control decoder: ALU op codes, multiply FSM state encoding and
//   the HI/LO read-select values.
package hilo_mult_unit_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_MULT  = 4'b0110;
  localparam logic [3:0] OP_MULTU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

  localparam logic HILO_SEL_HI = 1'b1;
  localparam logic HILO_SEL_LO = 1'b0;

endpackage

// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if
//   Execute-stage bus between the pipeline/control side (master) and the
//   HI/LO multiply unit (slave).
//   master drives : op_EX, enhilo_EX, a_EX, b_EX, hilo_sel_EX
//   slave drives  : hilo_rdata_EX, stall_EX, busy
//
//   Handshake: there is no valid/ready pair. A request is the pair
//   (enhilo_EX, op_EX == mult) held in EX; it is accepted on the first
//   rising edge where the unit is IDLE. stall_EX is high from the accept
//   cycle through the last RUN cycle, which keeps the request (and the rest
//   of the pipeline) frozen; the request leaves EX on the edge that ends
//   FINISH, which is also the edge that writes HI/LO.
interface hilo_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op_EX;
  logic             enhilo_EX;
  logic [WIDTH-1:0] a_EX;
  logic [WIDTH-1:0] b_EX;
  logic             hilo_sel_EX;
  logic [WIDTH-1:0] hilo_rdata_EX;
  logic             stall_EX;
  logic             busy;

  modport master (
    output op_EX, enhilo_EX, a_EX, b_EX, hilo_sel_EX,
    input  hilo_rdata_EX, stall_EX, busy
  );

  modport slave (
    input  op_EX, enhilo_EX, a_EX, b_EX, hilo_sel_EX,
    output hilo_rdata_EX, stall_EX, busy
  );
endinterface

// File: rtl/hilo_mult_unit_shift_add_core.sv
// shift_add_core
//   Unsigned shift-add datapath: one multiplier bit per step.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     load       : capture operands, clear accumulator and counter
//     step       : perform one iteration (add mcand << cnt if mplier[0])
//     mcand_in   : unsigned multiplicand
//     mplier_in  : unsigned multiplier
//     acc        : 2*WIDTH accumulator (final product after WIDTH steps)
//     last       : current step is the final iteration (cnt == WIDTH-1)
module shift_add_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] addend;

  // Multiplicand is zero-extended to the accumulator width before shifting
  // so that no high bits are lost at large counts.
  assign addend = {{WIDTH{1'b0}}, mcand} << cnt;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= '0;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + addend;
      end
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit
//   Execute-stage multicycle signed multiply writing the HI/LO pair, plus the
//   HI/LO read port for mfhi/mflo.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : hilo_mult_unit_if.slave (op/enhilo/operands/read select in,
//                 read data, stall and busy out)
//     dbg_state : current FSM state
//   Build option: define MULTU_EN to also accept op 4'b0111 as an unsigned
//   multiply (same latency, no sign handling).
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6   // 2**CNT_W must exceed WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  hilo_mult_unit_if.slave         bus,
  output mult_state_e             dbg_state
);

  mult_state_e        state;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;

  logic               is_mult;
  logic               signed_op;
  logic               start;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;
  logic               last;

`ifdef MULTU_EN
  assign is_mult   = (bus.op_EX == OP_MULT) || (bus.op_EX == OP_MULTU);
  assign signed_op = (bus.op_EX == OP_MULT);
`else
  assign is_mult   = (bus.op_EX == OP_MULT);
  assign signed_op = 1'b1;
`endif

  assign start = (state == IDLE) && bus.enhilo_EX && is_mult;

  // Negating the most-negative value wraps back to itself, which read as
  // unsigned is exactly 2**(WIDTH-1), so the magnitude is still correct.
  assign a_abs = (signed_op && bus.a_EX[WIDTH-1]) ? -bus.a_EX : bus.a_EX;
  assign b_abs = (signed_op && bus.b_EX[WIDTH-1]) ? -bus.b_EX : bus.b_EX;

  assign product = neg ? -acc : acc;

  shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .step      (state == RUN),
    .mcand_in  (a_abs),
    .mplier_in (b_abs),
    .acc       (acc),
    .last      (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg   <= signed_op && (bus.a_EX[WIDTH-1] ^ bus.b_EX[WIDTH-1]);
            state <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          {hi, lo} <= product;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is released in FINISH so the mult leaves EX on the same edge
  // that writes HI/LO; the FSM is not IDLE then, so it cannot restart.
  assign bus.stall_EX      = start || (state == RUN);
  assign bus.busy          = (state != IDLE);
  assign bus.hilo_rdata_EX = (bus.hilo_sel_EX == HILO_SEL_HI) ? hi : lo;
  assign dbg_state         = state;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit
//   Directed bench for hilo_mult_unit: signed multiplies, idle/no-start
//   cases, op held through FINISH, reset mid-operation and the optional
//   unsigned op (MULTU_EN).
module tb_hilo_mult_unit;
  import hilo_mult_unit_pkg::*;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  mult_state_e dbg_state;
  int          checks;
  int          errors;
  int          scyc;

  hilo_mult_unit_if #(.WIDTH(W)) bus ();

  hilo_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    bus.hilo_sel_EX = HILO_SEL_HI;
    #1;
    chk({tag, "_hi"}, bus.hilo_rdata_EX, exp_hi);
    bus.hilo_sel_EX = HILO_SEL_LO;
    #1;
    chk({tag, "_lo"}, bus.hilo_rdata_EX, exp_lo);
  endtask

  // Present a request, count stall cycles, scramble operands after accept,
  // hold the op through FINISH and drop it once the unit is IDLE again.
  task automatic do_mult(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stall_cycles);
    bus.op_EX     = op;
    bus.enhilo_EX = 1'b1;
    bus.a_EX      = a;
    bus.b_EX      = b;
    #1;
    stall_cycles = 0;
    for (int i = 0; i < 100 && bus.stall_EX; i++) begin
      stall_cycles++;
      tick();
      if (i == 0) begin
        bus.a_EX = 32'hDEAD_BEEF;
        bus.b_EX = 32'h1234_5677;
      end
    end
    if (stall_cycles > 0) begin
      chk("finish_busy", {31'd0, bus.busy}, 32'd1);
      chk("finish_state", {30'd0, dbg_state}, {30'd0, FINISH});
      tick();
    end
    bus.op_EX     = OP_ADD;
    bus.enhilo_EX = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.op_EX       = OP_ADD;
    bus.enhilo_EX   = 1'b0;
    bus.a_EX        = '0;
    bus.b_EX        = '0;
    bus.hilo_sel_EX = HILO_SEL_LO;
    tick();
    tick();

    // reset state
    chk("rst_stall", {31'd0, bus.stall_EX}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    read_hilo("rst", 32'h0, 32'h0);
    rst = 1'b0;
    tick();

    // 3 x 5
    do_mult(OP_MULT, 32'd3, 32'd5, scyc);
    chk("m3x5_stall", scyc, 32'd33);
    chk("m3x5_idle_busy", {31'd0, bus.busy}, 32'd0);
    read_hilo("m3x5", 32'h0000_0000, 32'h0000_000F);

    // -2 x 3
    do_mult(OP_MULT, 32'hFFFF_FFFE, 32'd3, scyc);
    chk("mneg_stall", scyc, 32'd33);
    read_hilo("mneg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // most-negative squared
    do_mult(OP_MULT, 32'h8000_0000, 32'h8000_0000, scyc);
    chk("mmin_stall", scyc, 32'd33);
    read_hilo("mmin", 32'h4000_0000, 32'h0000_0000);

    // max positive x most negative: -(2^62 - 2^31)
    do_mult(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, scyc);
    chk("mmix_stall", scyc, 32'd33);
    read_hilo("mmix", 32'hC000_0000, 32'h8000_0000);

    // op held through FINISH must not have restarted
    tick();
    chk("held_busy", {31'd0, bus.busy}, 32'd0);
    chk("held_stall", {31'd0, bus.stall_EX}, 32'd0);

    // add with enhilo low: no start
    bus.op_EX = OP_ADD; bus.enhilo_EX = 1'b0; bus.a_EX = 32'd9; bus.b_EX = 32'd9;
    #1;
    chk("add_en0_stall", {31'd0, bus.stall_EX}, 32'd0);
    tick();
    chk("add_en0_busy", {31'd0, bus.busy}, 32'd0);
    // add with enhilo high: no start
    bus.enhilo_EX = 1'b1;
    #1;
    chk("add_en1_stall", {31'd0, bus.stall_EX}, 32'd0);
    tick();
    chk("add_en1_busy", {31'd0, bus.busy}, 32'd0);
    // mult with enhilo low: no start
    bus.op_EX = OP_MULT; bus.enhilo_EX = 1'b0;
    #1;
    chk("mult_en0_stall", {31'd0, bus.stall_EX}, 32'd0);
    tick();
    tick();
    chk("mult_en0_busy", {31'd0, bus.busy}, 32'd0);
    bus.op_EX = OP_ADD;
    read_hilo("noop", 32'hC000_0000, 32'h8000_0000);

    // reset at cycle 10 of a 7 x 7 multiply
    bus.op_EX = OP_MULT; bus.enhilo_EX = 1'b1; bus.a_EX = 32'd7; bus.b_EX = 32'd7;
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    bus.op_EX = OP_ADD; bus.enhilo_EX = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, bus.stall_EX}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    read_hilo("mid_rst", 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    do_mult(OP_MULT, 32'd7, 32'd7, scyc);
    chk("m7x7_stall", scyc, 32'd33);
    read_hilo("m7x7", 32'h0000_0000, 32'h0000_0031);

    // unsigned op
`ifdef MULTU_EN
    do_mult(OP_MULTU, 32'hFFFF_FFFF, 32'd2, scyc);
    chk("multu_stall", scyc, 32'd33);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
`else
    do_mult(OP_MULTU, 32'hFFFF_FFFF, 32'd2, scyc);
    chk("multu_off_stall", scyc, 32'd0);
    tick();
    tick();
    chk("multu_off_busy", {31'd0, bus.busy}, 32'd0);
    read_hilo("multu_off", 32'h0000_0000, 32'h0000_0031);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
